// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared FSM encodings and access-size codes for the memory port arbiter
package mem_port_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_RD_I = 2'd1;
  localparam logic [1:0] ARB_RD_D = 2'd2;

  typedef logic [2:0] dmtype_t;

  // Same encoding the CPU control unit drives on DMType_out
  localparam dmtype_t DM_WORD     = 3'b000;
  localparam dmtype_t DM_HALF     = 3'b001;
  localparam dmtype_t DM_HALF_U   = 3'b010;
  localparam dmtype_t DM_BYTE     = 3'b011;
  localparam dmtype_t DM_BYTE_U   = 3'b100;

  function automatic logic is_load(input logic req, input logic we);
    return req & ~we;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - CPU fetch/data ports, memory port and pipeline status bundle
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_flush;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  dmtype_t           d_dmtype;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  dmtype_t           m_dmtype;
  logic              m_ready;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  logic              stall_if;
  logic              stall_mem;
  logic              busy;
  logic              err_spurious;

  modport slave (
    input  i_req, i_addr, i_flush,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_dmtype,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_addr, m_wdata, m_dmtype,
    input  m_ready, m_rvalid, m_rdata,
    output stall_if, stall_mem, busy, err_spurious
  );

  modport master (
    output i_req, i_addr, i_flush,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_dmtype,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_addr, m_wdata, m_dmtype,
    output m_ready, m_rvalid, m_rdata,
    input  stall_if, stall_mem, busy, err_spurious
  );

endinterface

// File: rtl/arb_starve_cnt.sv
// rtl/arb_starve_cnt.sv - saturating count of data grants issued while a fetch is waiting
module arb_starve_cnt #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LP_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sat = (r_cnt == LP_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding arbiter sharing one memory port between fetch and load/store
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic              clk,
  input  logic              rstn,
  mem_port_arbiter_if.slave io_bus
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              r_flush;
  logic              r_err;

  logic              w_run;
  logic              w_idle;
  logic              w_rd_i;
  logic              w_rd_d;
  logic              w_i_act;
  logic              w_sel_i;
  logic              w_sel_d;
  logic              w_m_req;
  logic              w_i_gnt;
  logic              w_d_gnt;
  logic              w_sat;
  logic              w_inc;
  logic              w_clr;
  logic              w_i_rvalid;
  logic              w_d_rvalid;
  logic              w_m_we;
  logic [ADDR_W-1:0] w_m_addr;
  logic [DATA_W-1:0] w_m_wdata;
  dmtype_t           w_m_dmtype;

  // Everything is gated by rstn so all outputs read 0 while reset is held
  assign w_run   = rstn;
  assign w_idle  = w_run & (r_state == ARB_IDLE);
  assign w_rd_i  = w_run & (r_state == ARB_RD_I);
  assign w_rd_d  = w_run & (r_state == ARB_RD_D);

  assign w_i_act = io_bus.i_req & ~io_bus.i_flush;
  assign w_sel_i = w_idle & w_i_act & (~io_bus.d_req | w_sat);
  assign w_sel_d = w_idle & io_bus.d_req & ~w_sel_i;
  assign w_m_req = w_sel_i | w_sel_d;

  assign w_i_gnt = w_sel_i & io_bus.m_ready;
  assign w_d_gnt = w_sel_d & io_bus.m_ready;

  always_comb begin
    w_m_we     = 1'b0;
    w_m_addr   = '0;
    w_m_wdata  = '0;
    w_m_dmtype = DM_WORD;
    if (w_sel_i) begin
      w_m_addr = io_bus.i_addr;
    end else if (w_sel_d) begin
      w_m_we     = io_bus.d_we;
      w_m_addr   = io_bus.d_addr;
      w_m_wdata  = io_bus.d_wdata;
      w_m_dmtype = io_bus.d_dmtype;
    end
  end

  // A flush in the same cycle as the read data drops it as well
  assign w_i_rvalid = w_rd_i & io_bus.m_rvalid & ~r_flush & ~io_bus.i_flush;
  assign w_d_rvalid = w_rd_d & io_bus.m_rvalid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_i_gnt)
          w_state_nxt = ARB_RD_I;
        else if (w_d_gnt && is_load(io_bus.d_req, io_bus.d_we))
          w_state_nxt = ARB_RD_D;
      end
      ARB_RD_I, ARB_RD_D: begin
        if (io_bus.m_rvalid)
          w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ARB_IDLE;
      r_flush <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rd_i && io_bus.m_rvalid)
        r_flush <= 1'b0;
      else if (w_rd_i && io_bus.i_flush)
        r_flush <= 1'b1;
      if (w_idle && io_bus.m_rvalid)
        r_err <= 1'b1;
    end
  end

  assign w_inc = w_d_gnt & w_i_act;
  assign w_clr = w_i_gnt | ~io_bus.i_req;

  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_starve (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (w_inc),
    .i_clr (w_clr),
    .o_sat (w_sat)
  );

  assign io_bus.m_req    = w_m_req;
  assign io_bus.m_we     = w_m_we;
  assign io_bus.m_addr   = w_m_addr;
  assign io_bus.m_wdata  = w_m_wdata;
  assign io_bus.m_dmtype = w_m_dmtype;

  assign io_bus.i_gnt    = w_i_gnt;
  assign io_bus.i_rvalid = w_i_rvalid;
  assign io_bus.i_rdata  = w_i_rvalid ? io_bus.m_rdata : '0;
  assign io_bus.d_gnt    = w_d_gnt;
  assign io_bus.d_rvalid = w_d_rvalid;
  assign io_bus.d_rdata  = w_d_rvalid ? io_bus.m_rdata : '0;

  assign io_bus.stall_if  = w_run & ((w_i_act & ~w_i_gnt) | (w_rd_i & ~w_i_rvalid));
  assign io_bus.stall_mem = w_run & ((io_bus.d_req & ~w_d_gnt) | (w_rd_d & ~io_bus.m_rvalid));
  assign io_bus.busy         = w_rd_i | w_rd_d;
  assign io_bus.err_spurious = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4),
    .CNT_W      (3)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_req    = 1'b0;
    bus.i_addr   = '0;
    bus.i_flush  = 1'b0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus.d_dmtype = DM_WORD;
    bus.m_ready  = 1'b0;
    bus.m_rvalid = 1'b0;
    bus.m_rdata  = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    rstn = 1'b0;

    // Reset held with requests present: outputs must stay 0
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    bus.m_ready = 1'b1;
    cyc(); settle();
    chk("rst_m_req", 32'(bus.m_req), 0);
    chk("rst_i_gnt", 32'(bus.i_gnt), 0);
    chk("rst_d_gnt", 32'(bus.d_gnt), 0);
    chk("rst_stall_if", 32'(bus.stall_if), 0);
    chk("rst_stall_mem", 32'(bus.stall_mem), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'(bus.err_spurious), 0);

    cyc();
    idle_inputs();
    rstn = 1'b1;
    settle();
    chk("post_rst_m_req", 32'(bus.m_req), 0);
    chk("post_rst_busy", 32'(bus.busy), 0);

    // Fetch only, L=2
    cyc();
    bus.i_req = 1'b1; bus.i_addr = 32'h0; bus.m_ready = 1'b1;
    settle();
    chk("f1_i_gnt", 32'(bus.i_gnt), 1);
    chk("f1_m_req", 32'(bus.m_req), 1);
    chk("f1_m_we", 32'(bus.m_we), 0);
    chk("f1_m_addr", bus.m_addr, 32'h0);
    cyc();
    bus.i_req = 1'b0; bus.m_ready = 1'b0;
    settle();
    chk("f1_busy_t1", 32'(bus.busy), 1);
    chk("f1_stall_if_t1", 32'(bus.stall_if), 1);
    chk("f1_rvalid_t1", 32'(bus.i_rvalid), 0);
    cyc();
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'h00500093;
    settle();
    chk("f1_rvalid_t2", 32'(bus.i_rvalid), 1);
    chk("f1_rdata_t2", bus.i_rdata, 32'h00500093);
    chk("f1_stall_if_t2", 32'(bus.stall_if), 0);
    chk("f1_busy_t2", 32'(bus.busy), 1);
    cyc();
    bus.m_rvalid = 1'b0; bus.m_rdata = '0;
    settle();
    chk("f1_busy_t3", 32'(bus.busy), 0);
    chk("f1_err", 32'(bus.err_spurious), 0);

    // Simultaneous fetch and load: data wins, fetch follows after d_rvalid
    cyc();
    bus.i_req = 1'b1; bus.i_addr = 32'h4;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100; bus.m_ready = 1'b1;
    settle();
    chk("sim_d_gnt", 32'(bus.d_gnt), 1);
    chk("sim_i_gnt", 32'(bus.i_gnt), 0);
    chk("sim_m_addr", bus.m_addr, 32'h100);
    chk("sim_stall_if_t0", 32'(bus.stall_if), 1);
    cyc();
    bus.d_req = 1'b0;
    settle();
    chk("sim_stall_if_t1", 32'(bus.stall_if), 1);
    chk("sim_stall_mem_t1", 32'(bus.stall_mem), 1);
    chk("sim_m_req_t1", 32'(bus.m_req), 0);
    cyc();
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'hDEADBEEF;
    settle();
    chk("sim_d_rvalid", 32'(bus.d_rvalid), 1);
    chk("sim_d_rdata", bus.d_rdata, 32'hDEADBEEF);
    chk("sim_i_rvalid_quiet", 32'(bus.i_rvalid), 0);
    chk("sim_stall_if_t2", 32'(bus.stall_if), 1);
    chk("sim_stall_mem_t2", 32'(bus.stall_mem), 0);
    cyc();
    bus.m_rvalid = 1'b0; bus.m_rdata = '0;
    settle();
    chk("sim_i_gnt_t3", 32'(bus.i_gnt), 1);
    chk("sim_m_addr_t3", bus.m_addr, 32'h4);
    cyc();
    bus.i_req = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h00000011;
    settle();
    chk("sim_i_rdata", bus.i_rdata, 32'h00000011);
    cyc();
    idle_inputs();
    settle();
    chk("sim_busy_end", 32'(bus.busy), 0);

    // Store stream with fetch waiting: exactly 4 stores, then the fetch
    bus.i_req = 1'b1; bus.i_addr = 32'h8;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h300;
    bus.d_wdata = 32'h0BADF00D; bus.d_dmtype = DM_BYTE; bus.m_ready = 1'b1;
    settle();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stv_d_gnt_%0d", k), 32'(bus.d_gnt), 1);
      chk($sformatf("stv_i_gnt_%0d", k), 32'(bus.i_gnt), 0);
      cyc(); settle();
    end
    chk("stv_i_gnt_sat", 32'(bus.i_gnt), 1);
    chk("stv_d_gnt_sat", 32'(bus.d_gnt), 0);
    chk("stv_m_we_fetch", 32'(bus.m_we), 0);
    cyc();
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'h00000013;
    settle();
    chk("stv_i_rvalid", 32'(bus.i_rvalid), 1);
    chk("stv_stall_mem", 32'(bus.stall_mem), 1);
    chk("stv_cnt_clr", 32'(dut.u_starve.r_cnt), 0);
    cyc();
    bus.m_rvalid = 1'b0; bus.m_rdata = '0;
    settle();
    chk("stv_d_resume", 32'(bus.d_gnt), 1);
    chk("stv_i_gnt_after", 32'(bus.i_gnt), 0);
    cyc();
    idle_inputs();

    // Flush in IDLE masks the fetch request
    bus.i_req = 1'b1; bus.i_flush = 1'b1; bus.m_ready = 1'b1;
    settle();
    chk("fli_m_req", 32'(bus.m_req), 0);
    chk("fli_stall_if", 32'(bus.stall_if), 0);

    // Flush during RD_I, data arrives a cycle later
    cyc();
    bus.i_flush = 1'b0; bus.i_addr = 32'hC;
    settle();
    chk("fl_i_gnt", 32'(bus.i_gnt), 1);
    cyc();
    bus.i_req = 1'b0; bus.i_flush = 1'b1;
    settle();
    chk("fl_rvalid_t1", 32'(bus.i_rvalid), 0);
    cyc();
    bus.i_flush = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h12345678;
    settle();
    chk("fl_rvalid_t2", 32'(bus.i_rvalid), 0);
    chk("fl_rdata_t2", bus.i_rdata, 32'h0);
    cyc();
    bus.m_rvalid = 1'b0; bus.m_rdata = '0;
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    settle();
    chk("fl_busy_idle", 32'(bus.busy), 0);
    chk("fl_err", 32'(bus.err_spurious), 0);
    chk("fl_next_gnt", 32'(bus.i_gnt), 1);
    cyc();
    bus.i_req = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h00000055;
    settle();
    chk("fl_next_rvalid", 32'(bus.i_rvalid), 1);
    chk("fl_next_rdata", bus.i_rdata, 32'h00000055);

    // Flush and data in the same cycle: data dropped
    cyc();
    bus.m_rvalid = 1'b0; bus.i_req = 1'b1; bus.i_addr = 32'h14;
    settle();
    chk("fls_i_gnt", 32'(bus.i_gnt), 1);
    cyc();
    bus.i_req = 1'b0; bus.i_flush = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h77777777;
    settle();
    chk("fls_rvalid", 32'(bus.i_rvalid), 0);
    cyc();
    idle_inputs();
    settle();
    chk("fls_busy", 32'(bus.busy), 0);

    // Store stalled by m_ready low for 3 cycles
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200;
    bus.d_wdata = 32'hA5A5A5A5; bus.d_dmtype = DM_WORD; bus.m_ready = 1'b0;
    settle();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mr_d_gnt_%0d", k), 32'(bus.d_gnt), 0);
      chk($sformatf("mr_stall_mem_%0d", k), 32'(bus.stall_mem), 1);
      chk($sformatf("mr_m_req_%0d", k), 32'(bus.m_req), 1);
      cyc(); settle();
    end
    bus.m_ready = 1'b1;
    settle();
    chk("mr_d_gnt", 32'(bus.d_gnt), 1);
    chk("mr_m_wdata", bus.m_wdata, 32'hA5A5A5A5);
    chk("mr_m_we", 32'(bus.m_we), 1);
    chk("mr_m_addr", bus.m_addr, 32'h200);
    chk("mr_stall_mem_gnt", 32'(bus.stall_mem), 0);
    cyc();
    idle_inputs();
    settle();
    chk("mr_busy_after_store", 32'(bus.busy), 0);
    chk("mr_no_d_rvalid", 32'(bus.d_rvalid), 0);

    // Reset while a load is outstanding; late data becomes spurious
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40; bus.m_ready = 1'b1;
    settle();
    chk("rs_d_gnt", 32'(bus.d_gnt), 1);
    cyc();
    bus.d_req = 1'b0;
    settle();
    chk("rs_busy_rd", 32'(bus.busy), 1);
    rstn = 1'b0;
    cyc(); settle();
    chk("rs_busy_in_rst", 32'(bus.busy), 0);
    chk("rs_stall_mem_in_rst", 32'(bus.stall_mem), 0);
    cyc();
    rstn = 1'b1;
    settle();
    chk("rs_busy_release", 32'(bus.busy), 0);
    cyc();
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'hCAFEF00D;
    settle();
    chk("rs_d_rvalid", 32'(bus.d_rvalid), 0);
    chk("rs_d_rdata", bus.d_rdata, 32'h0);
    cyc();
    bus.m_rvalid = 1'b0; bus.m_rdata = '0;
    settle();
    chk("rs_err_set", 32'(bus.err_spurious), 1);
    chk("rs_busy_idle", 32'(bus.busy), 0);
    cyc(); cyc(); settle();
    chk("rs_err_sticky", 32'(bus.err_spurious), 1);
    rstn = 1'b0;
    cyc(); settle();
    chk("rs_err_cleared", 32'(bus.err_spurious), 0);
    rstn = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port unified instruction/data memory between the pipelined CPU's IF-stage fetch port and MEM-stage load/store port. The block sits between the CPU's two memory interfaces and the memory wrapper. It allows one outstanding transaction at a time. It produces the stall signals the pipeline control uses to freeze IF/ID and EX/MEM.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, max consecutive data grants while a fetch waits (1..7)
- CNT_W, 3, starvation counter width
- clk  in  1  system clock; all state updates on rising edge
- rstn  in  1  reset, synchronous and active-low
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  ADDR_W  fetch address (PC_out)
- i_flush  in  1  discard current/pending fetch (branch/jump redirect)
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request; held with payload until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address (Addr_out)
- d_wdata  in  DATA_W  store data (Data_out)
- d_dmtype  in  3  access size/sign code (DMType_out)
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- m_req, m_we  out  1  memory request / write enable
- m_addr  out  ADDR_W; m_wdata  out  DATA_W; m_dmtype  out  3  memory payload
- m_ready  in  1  memory accepts request this cycle
- m_rvalid  in  1  memory read data valid
- m_rdata  in  DATA_W  memory read data
- stall_if  out  1  freeze IF stage
- stall_mem  out  1  freeze MEM and earlier stages
- busy  out  1  read outstanding
- err_spurious  out  1  sticky: m_rvalid seen in IDLE

## Operation
- FSM states are IDLE, RD_I, RD_D.
- Requests are issued only in IDLE. The m_* outputs are combinational from the selected requester, and m_req is 0 when nothing is selected.
- Selection in IDLE:
  - If only one requester is active, select it.
  - If both are active, data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - If i_flush is high, i_req is ignored that cycle.
- The grant for the selected requester equals m_req & m_ready. There is no grant without m_ready.
- Store (d_we=1): the store completes on its grant and the FSM stays in IDLE. Stores never raise d_rvalid.
- Load or fetch grant: go to RD_D or RD_I. Wait for m_rvalid, then route m_rdata to the requester's rdata/rvalid combinationally in the same cycle, and return to IDLE on the next edge.
- Fetch never writes: m_we = 0 whenever fetch is selected.
- Flush during RD_I: a flag is set, and the matching m_rvalid is consumed without raising i_rvalid. If flush and m_rvalid occur in the same cycle, the data is dropped.
- starve_cnt:
  - Increments on a data grant while i_req is high and i_flush is low, saturating at STARVE_MAX.
  - Clears on a fetch grant, or when i_req is low.
- m_rvalid in IDLE sets err_spurious. The data is dropped.
- stall_if = (i_req & ~i_flush & ~i_gnt) | (state==RD_I & ~i_rvalid).
- stall_mem = (d_req & ~d_gnt & ~d_we) | (d_req & d_we & ~d_gnt) | (state==RD_D & ~m_rvalid).
- busy = state != IDLE.

## Timing
- Reset (rstn=0 at a clk edge):
  - State returns to IDLE, and starve_cnt, the flush flag and err_spurious clear.
  - All outputs are 0 during and after reset until a request arrives.
  - An outstanding read is abandoned. Its late m_rvalid is dropped and sets err_spurious.
- Read latency: grant at cycle t, and memory rvalid at t+L gives requester rvalid at t+L (zero added latency).
- The next grant is possible at t+L+1.
- Back-to-back stores: one per cycle while m_ready is high.
- With m_ready low, the request is held and grants stay 0. Selection is re-evaluated every cycle, and stall signals stay asserted.
- Payload must be stable from req rise through gnt. The arbiter does not register the payload.

## Structure
- Shared definitions file holds:
  - FSM state encodings (ARB_IDLE=2'd0, ARB_RD_I=2'd1, ARB_RD_D=2'd2).
  - DMType codes, reused unchanged from the CPU's control encoding.
- One sub-module, arb_starve_cnt: a saturating counter with inc, clr and sat outputs, parameterised by STARVE_MAX and CNT_W.
- The FSM, muxing and stall logic are in the top module.

## Test plan
- Fetch only, i_addr=0x0, memory L=2 returning 0x00500093: i_gnt at t, i_rvalid with i_rdata=0x00500093 at t+2, stall_if high from t to t+1, busy low at t+3.
- Simultaneous i_req/d_req (load from 0x100 returning 0xDEADBEEF): d_gnt first, d_rdata=0xDEADBEEF, i_gnt on the cycle after d_rvalid, stall_if high throughout the wait.
- Continuous store stream with i_req held high, STARVE_MAX=4: exactly 4 d_gnt, then i_gnt, then starve_cnt=0 and data resumes.
- i_flush asserted during RD_I, memory returns 0x12345678: i_rvalid stays 0, FSM returns to IDLE, next i_req is granted normally.
- Reset mid-RD_D, then m_rvalid arrives 1 cycle after reset release: d_rvalid stays 0, err_spurious goes to 1 and stays until the next reset, state is IDLE.
- m_ready held low for 3 cycles with d_req store to 0x200, d_wdata=0xA5A5A5A5: no d_gnt and stall_mem=1 for 3 cycles, then d_gnt with m_wdata=0xA5A5A5A5, m_we=1.
